// File: rtl/apb_manager.sv
// APB manager: turns a valid/ready request into one APB transfer and returns the response.
// Optional ACCESS wait-state timeout is compiled in with `define APB_MANAGER_TIMEOUT_EN.
module apb_manager #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic [AddrWidth-1:0] reqAddr,
  input  logic [DataWidth-1:0] reqWData,
  input  logic                 reqWrite,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [DataWidth-1:0] rspRData,
  output logic                 rspErr,
  output logic                 rspTimeout,
  output logic [AddrWidth-1:0] addr,
  output logic [DataWidth-1:0] wData,
  output logic                 write,
  output logic                 sel,
  output logic                 enable,
  input  logic [DataWidth-1:0] rData,
  input  logic                 subErr,
  input  logic                 readyOut
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;
  state_t state_next;
  logic   req_accept;
  logic   access_timeout;
  logic   sel_next;
  logic   enable_next;
  logic   rsp_valid_next;
  logic   req_ready_next;

  if (TimeoutCycles < 1) begin : g_param_check
    $error("apb_manager: TimeoutCycles must be at least 1");
  end

  // A request is taken only when the registered reqReady was already visible to the requester.
  assign req_accept = (state == IDLE) && reqValid && reqReady;

`ifdef APB_MANAGER_TIMEOUT_EN
  localparam int CntWidth = $clog2(TimeoutCycles + 1);

  logic [CntWidth-1:0] wait_cnt;

  assign access_timeout = (state == ACCESS) && !readyOut &&
                          (wait_cnt == CntWidth'(TimeoutCycles - 1));

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wait_cnt   <= '0;
      rspTimeout <= 1'b0;
    end else begin
      if (state_next == SETUP) begin
        wait_cnt <= '0;
      end else if (state == ACCESS && !readyOut) begin
        wait_cnt <= wait_cnt + CntWidth'(1);
      end
      if (state == ACCESS && readyOut) begin
        rspTimeout <= 1'b0;
      end else if (access_timeout) begin
        rspTimeout <= 1'b1;
      end
    end
  end
`else
  assign access_timeout = 1'b0;
  assign rspTimeout     = 1'b0;
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      sel      <= 1'b0;
      enable   <= 1'b0;
      rspValid <= 1'b0;
      reqReady <= 1'b0;
    end else begin
      state    <= state_next;
      sel      <= sel_next;
      enable   <= enable_next;
      rspValid <= rsp_valid_next;
      reqReady <= req_ready_next;
    end
  end

  // Handshake outputs are decoded from the next state so they are registered yet cycle-exact.
  always_comb begin
    state_next     = state;
    sel_next       = 1'b0;
    enable_next    = 1'b0;
    rsp_valid_next = 1'b0;
    req_ready_next = 1'b0;
    case (state)
      IDLE:    if (req_accept) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (readyOut || access_timeout) state_next = RESP;
      RESP:    if (rspReady) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    case (state_next)
      IDLE:    req_ready_next = 1'b1;
      SETUP:   sel_next       = 1'b1;
      ACCESS: begin
        sel_next    = 1'b1;
        enable_next = 1'b1;
      end
      RESP:    rsp_valid_next = 1'b1;
      default: req_ready_next = 1'b0;
    endcase
  end

  // Transfer fields hold their last value; response fields only move when ACCESS completes.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      addr     <= '0;
      wData    <= '0;
      write    <= 1'b0;
      rspRData <= '0;
      rspErr   <= 1'b0;
    end else begin
      if (req_accept) begin
        addr  <= reqAddr;
        wData <= reqWData;
        write <= reqWrite;
      end
      if (state == ACCESS && readyOut) begin
        rspErr   <= subErr;
        rspRData <= write ? '0 : rData;
      end else if (access_timeout) begin
        rspErr   <= 1'b1;
        rspRData <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_manager.sv
// Self-checking bench for apb_manager: scoreboard of expected responses plus APB phase checks.
// Build with APB_MANAGER_TIMEOUT_EN defined to exercise the timeout path instead of the endless wait.
module tb_apb_manager;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
  } rsp_t;

  logic          clk = 1'b0;
  logic          nReset;
  logic          reqValid = 1'b0;
  logic          reqReady;
  logic [AW-1:0] reqAddr = '0;
  logic [DW-1:0] reqWData = '0;
  logic          reqWrite = 1'b0;
  logic          rspValid;
  logic          rspReady = 1'b0;
  logic [DW-1:0] rspRData;
  logic          rspErr;
  logic          rspTimeout;
  logic [AW-1:0] addr;
  logic [DW-1:0] wData;
  logic          write;
  logic          sel;
  logic          enable;
  logic [DW-1:0] rData = '0;
  logic          subErr = 1'b0;
  logic          readyOut = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   edges;
  rsp_t sb[$];

  apb_manager #(
    .AddrWidth    (AW),
    .DataWidth    (DW),
    .TimeoutCycles(TMO)
  ) dut (
    .clk       (clk),
    .nReset    (nReset),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqAddr   (reqAddr),
    .reqWData  (reqWData),
    .reqWrite  (reqWrite),
    .rspValid  (rspValid),
    .rspReady  (rspReady),
    .rspRData  (rspRData),
    .rspErr    (rspErr),
    .rspTimeout(rspTimeout),
    .addr      (addr),
    .wData     (wData),
    .write     (write),
    .sel       (sel),
    .enable    (enable),
    .rData     (rData),
    .subErr    (subErr),
    .readyOut  (readyOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and plays the APB subordinate with the given wait states.
  task automatic applyStimulus(input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic wr,
                               input int waits, input logic [DW-1:0] rd, input logic err,
                               output int accept_edges);
    rsp_t e;
    e.rdata = wr ? '0 : rd;
    e.err   = err;
    e.tmo   = 1'b0;
    sb.push_back(e);
    reqValid = 1'b1;
    reqAddr  = a;
    reqWData = wd;
    reqWrite = wr;
    accept_edges = 0;
    while (accept_edges < 20 && !sel) begin
      tick();
      accept_edges++;
    end
    reqValid = 1'b0;
    checkOutput("accept_sel", sel, 1);
    if (!sel) return;
    checkOutput("setup_enable", enable, 0);
    checkOutput("setup_addr", addr, a);
    checkOutput("setup_write", write, wr);
    if (wr) checkOutput("setup_wdata", wData, wd);
    tick();
    checkOutput("access_enable", enable, 1);
    for (int i = 0; i <= waits; i++) begin
      readyOut = (i == waits);
      rData    = (i == waits) ? rd : ~rd;
      subErr   = (i == waits) ? err : ~err;
      if (i > 0) begin
        checkOutput("wait_enable", enable, 1);
        checkOutput("wait_addr", addr, a);
      end
      tick();
    end
    readyOut = 1'b0;
    subErr   = 1'b0;
    rData    = '0;
    checkOutput("resp_sel", sel, 0);
    checkOutput("resp_enable", enable, 0);
  endtask

  // Waits for a response, holds it for 'hold' cycles, then completes the handshake.
  task automatic collectResponse(input int hold);
    rsp_t e;
    for (int i = 0; i < 20 && !rspValid; i++) tick();
    checkOutput("rsp_valid", rspValid, 1);
    if (!rspValid) return;
    if (sb.size() == 0) begin
      checkOutput("unexpected_rsp", rspValid, 0);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) tick();
      checkOutput("rsp_valid_hold", rspValid, 1);
      checkOutput("rsp_rdata", rspRData, e.rdata);
      checkOutput("rsp_err", rspErr, e.err);
      checkOutput("rsp_timeout", rspTimeout, e.tmo);
      checkOutput("rsp_req_ready", reqReady, 0);
      checkOutput("rsp_sel", sel, 0);
    end
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    checkOutput("rsp_done_valid", rspValid, 0);
    checkOutput("rsp_done_sel", sel, 0);
  endtask

  task automatic backToBack();
    rsp_t          e;
    int            sel_at[2];
    int            rsp_at[2];
    logic [AW-1:0] sel_addr[2];
    int            nsel;
    int            nrsp;
    logic          prev_sel;
    logic          prev_rsp;
    nsel = 0;
    nrsp = 0;
    sel_at = '{0, 0};
    rsp_at = '{0, 0};
    sel_addr = '{'0, '0};
    e.err = 1'b0;
    e.tmo = 1'b0;
    e.rdata = 32'h0000AAAA;
    sb.push_back(e);
    e.rdata = 32'h0000BBBB;
    sb.push_back(e);
    reqValid = 1'b1;
    reqAddr  = 32'h40;
    reqWrite = 1'b0;
    readyOut = 1'b1;
    rspReady = 1'b1;
    rData    = 32'h0000AAAA;
    prev_sel = sel;
    prev_rsp = rspValid;
    for (int k = 1; k <= 30 && nrsp < 2; k++) begin
      tick();
      if (sel && !prev_sel && nsel < 2) begin
        sel_at[nsel]   = k;
        sel_addr[nsel] = addr;
        nsel++;
        if (nsel == 1) reqAddr = 32'h44;
        else reqValid = 1'b0;
      end
      if (rspValid && !prev_rsp && nrsp < 2 && sb.size() > 0) begin
        rsp_at[nrsp] = k;
        e = sb.pop_front();
        checkOutput("b2b_rdata", rspRData, e.rdata);
        checkOutput("b2b_err", rspErr, e.err);
        nrsp++;
        rData = 32'h0000BBBB;
      end
      prev_sel = sel;
      prev_rsp = rspValid;
    end
    tick();
    reqValid = 1'b0;
    readyOut = 1'b0;
    rspReady = 1'b0;
    checkOutput("b2b_done_valid", rspValid, 0);
    checkOutput("b2b_rsp_count", nrsp, 2);
    checkOutput("b2b_gap", sel_at[1] - rsp_at[0], 2);
    checkOutput("b2b_addr0", sel_addr[0], 32'h40);
    checkOutput("b2b_addr1", sel_addr[1], 32'h44);
  endtask

  task automatic timeoutTest();
    rsp_t e;
    int   en_cycles;
    en_cycles = 0;
    reqValid = 1'b1;
    reqAddr  = 32'h50;
    reqWrite = 1'b0;
    readyOut = 1'b0;
    rData    = 32'hFFFF;
    for (int i = 0; i < 20 && !sel; i++) tick();
    reqValid = 1'b0;
    checkOutput("tmo_accept", sel, 1);
    tick();
`ifdef APB_MANAGER_TIMEOUT_EN
    e.rdata = '0;
    e.err   = 1'b1;
    e.tmo   = 1'b1;
    sb.push_back(e);
    while (enable && en_cycles < 150) begin
      en_cycles++;
      tick();
    end
    checkOutput("tmo_enable_cycles", en_cycles, TMO);
    rData = '0;
    collectResponse(0);
`else
    e.rdata = 32'h99;
    e.err   = 1'b0;
    e.tmo   = 1'b0;
    sb.push_back(e);
    while (enable && en_cycles < 110) begin
      en_cycles++;
      tick();
    end
    checkOutput("no_tmo_enable_cycles", en_cycles, 110);
    checkOutput("no_tmo_rsp_valid", rspValid, 0);
    readyOut = 1'b1;
    rData    = 32'h99;
    tick();
    readyOut = 1'b0;
    rData    = '0;
    collectResponse(0);
`endif
  endtask

  task automatic resetMidTransfer();
    logic seen;
    seen = 1'b0;
    reqValid = 1'b1;
    reqAddr  = 32'h60;
    reqWData = 32'h1111;
    reqWrite = 1'b1;
    readyOut = 1'b0;
    for (int i = 0; i < 20 && !sel; i++) tick();
    reqValid = 1'b0;
    tick();
    checkOutput("mid_enable", enable, 1);
    #2 nReset = 1'b0;
    #1;
    checkOutput("mid_rst_sel", sel, 0);
    checkOutput("mid_rst_enable", enable, 0);
    checkOutput("mid_rst_rsp_valid", rspValid, 0);
    checkOutput("mid_rst_req_ready", reqReady, 0);
    checkOutput("mid_rst_addr", addr, 0);
    tick();
    nReset = 1'b1;
    checkOutput("mid_release_ready", reqReady, 0);
    tick();
    checkOutput("mid_ready_after", reqReady, 1);
    readyOut = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | rspValid | sel;
    end
    readyOut = 1'b0;
    checkOutput("no_stale_rsp", seen, 0);
  endtask

  initial begin
    nReset = 1'b1;
    #1 nReset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_sel", sel, 0);
    checkOutput("rst_enable", enable, 0);
    checkOutput("rst_rsp_valid", rspValid, 0);
    checkOutput("rst_req_ready", reqReady, 0);
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_wdata", wData, 0);
    checkOutput("rst_write", write, 0);
    checkOutput("rst_rdata", rspRData, 0);
    checkOutput("rst_err", rspErr, 0);
    checkOutput("rst_timeout", rspTimeout, 0);
    #3 nReset = 1'b1;
    checkOutput("release_ready", reqReady, 0);
    tick();
    checkOutput("ready_after_reset", reqReady, 1);

    applyStimulus(32'h10, 32'hDEADBEEF, 1'b1, 0, 32'h5A5A5A5A, 1'b0, edges);
    checkOutput("write_accept_edges", edges, 1);
    collectResponse(0);

    applyStimulus(32'h4, 32'h0, 1'b0, 3, 32'h1234, 1'b0, edges);
    collectResponse(0);

    applyStimulus(32'h8, 32'h0, 1'b0, 0, 32'hBAD0, 1'b1, edges);
    reqValid = 1'b1;
    reqAddr  = 32'h20;
    reqWData = 32'hCAFE;
    reqWrite = 1'b1;
    collectResponse(5);
    applyStimulus(32'h20, 32'hCAFE, 1'b1, 1, 32'h0, 1'b0, edges);
    checkOutput("resp_then_accept_edges", edges, 1);
    collectResponse(0);

    backToBack();
    timeoutTest();
    resetMidTransfer();

    checkOutput("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/apb_manager.md
APB_MANAGER -- requirements
Module: apb_manager

Interface
REQ-001 The block SHALL have parameter AddrWidth, default 32, APB address width.
REQ-002 The block SHALL have parameter DataWidth, default 32, APB data width.
REQ-003 The block SHALL have parameter TimeoutCycles, default 16, ACCESS wait-cycle limit (used only per REQ-030).
REQ-004 The block SHALL have port clk  input  1  PCLK; all state changes on rising edge.
REQ-005 The block SHALL have port nReset  input  1  PRESETn; asynchronous, active-low.
REQ-006 The block SHALL have ports reqValid input 1, reqReady output 1: request handshake.
REQ-007 The block SHALL have ports reqAddr input AddrWidth, reqWData input DataWidth, reqWrite input 1 (1=write): request payload.
REQ-008 The block SHALL have ports rspValid output 1, rspReady input 1: response handshake.
REQ-009 The block SHALL have ports rspRData output DataWidth, rspErr output 1, rspTimeout output 1: response payload.
REQ-010 The block SHALL have APB outputs addr AddrWidth, wData DataWidth, write 1, sel 1, enable 1 (PADDR, PWDATA, PWRITE, PSEL, PENABLE).
REQ-011 The block SHALL have APB inputs rData DataWidth, subErr 1, readyOut 1 (PRDATA, PSLVERR, PREADY).

Function
REQ-012 The block SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-013 IDLE: reqReady=1, sel=0, enable=0; on reqValid=1 latch reqAddr/reqWData/reqWrite into addr/wData/write, go SETUP.
REQ-014 SETUP: sel=1, enable=0, reqReady=0; unconditionally go ACCESS next cycle.
REQ-015 ACCESS: sel=1, enable=1; stay while readyOut=0; on readyOut=1 go RESP.
REQ-016 On ACCESS exit with readyOut=1: rspErr<=subErr; rspRData<=rData if write=0, else 0; rspTimeout<=0.
REQ-017 RESP: sel=0, enable=0, rspValid=1; payload held stable until rspReady=1, then go IDLE, rspValid=0.
REQ-018 addr, wData, write SHALL be stable from SETUP through ACCESS end and SHALL retain last values otherwise.
REQ-019 Minimum latency: request accepted at edge N -> sel=1 after N, enable=1 after N+1, rspValid=1 after N+2 (readyOut=1 on first ACCESS cycle).
REQ-020 Throughput: at most one outstanding transfer; reqReady=0 in SETUP, ACCESS, RESP; reqValid ignored there.
REQ-021 rspReady=1 while rspValid=0 SHALL have no effect.
REQ-022 subErr and rData SHALL be ignored except on the ACCESS cycle where readyOut=1.
REQ-023 reqValid and rspReady high together in RESP: only the response completes; the request is accepted next cycle in IDLE.

Reset
REQ-024 nReset=0 SHALL asynchronously force state IDLE, sel=0, enable=0, rspValid=0, reqReady=0.
REQ-025 Under reset addr=0, wData=0, write=0, rspRData=0, rspErr=0, rspTimeout=0; timeout counter=0.
REQ-026 reqReady SHALL rise on the first clk edge after nReset deasserts.
REQ-027 Reset mid-transfer SHALL abort it with no response; sel/enable drop without clk.

Configuration
REQ-028 Macro APB_MANAGER_TIMEOUT_EN SHALL compile the ACCESS timeout in or out.
REQ-029 Without the macro: ACCESS waits indefinitely for readyOut; rspTimeout tied 0; no counter logic.
REQ-030 With the macro: counter of ACCESS cycles with readyOut=0 (cleared on entering SETUP); when it reaches TimeoutCycles with readyOut still 0, go RESP with rspErr=1, rspTimeout=1, rspRData=0; readyOut=1 on that same cycle wins (normal completion).

Verification
REQ-031 Write: reqAddr=0x10, reqWData=0xDEADBEEF, reqWrite=1, readyOut=1 -> sel 1 cycle with enable=0, 1 cycle with enable=1, addr=0x10, wData=0xDEADBEEF; rspValid with rspErr=0, rspRData=0.
REQ-032 Read with 3 wait states: reqAddr=0x4, readyOut=0 for 3 ACCESS cycles then 1 with rData=0x1234 -> enable high 4 cycles, rspRData=0x1234, rspErr=0.
REQ-033 Error: subErr=1 with readyOut=1 -> rspErr=1; rspValid held 5 cycles with rspReady=0, payload unchanged; reqValid=1 during RESP not accepted.
REQ-034 Reset: nReset=0 during ACCESS -> sel=0, enable=0, rspValid=0 immediately; after release reqReady=1 next edge, no stale response.
REQ-035 APB_MANAGER_TIMEOUT_EN, TimeoutCycles=4, readyOut held 0 -> enable high 4 cycles, then rspValid with rspErr=1, rspTimeout=1; without macro enable stays high 100+ cycles.
REQ-036 Back-to-back: reqValid held 1 with 2 queued requests and rspReady=1 -> second sel rises 2 cycles after first rspValid, addresses in order.
